// File: rtl/ysyx_22040125_pkg.sv
// Shared constants for the write-back scheduler slice.
// Register-file geometry, requester count and requester indices.
package ysyx_22040125_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;
  localparam int NREQ   = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;

  function automatic logic [NREG-1:0] reg_onehot(
    input logic [REG_AW-1:0] a
  );
    logic [NREG-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ysyx_22040125_rr_arb.sv
// Round-robin arbiter: lowest requester at or above ptr_i wins,
// else lowest overall. Ports: req_i, ptr_i -> gnt_o, idx_o, any_o.
module ysyx_22040125_rr_arb #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] sel;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (IW'(i) >= ptr_i);
    end
  end

  // Requests at/above the pointer take precedence; wrap otherwise.
  assign sel   = (|(req_i & hi_mask)) ? (req_i & hi_mask) : req_i;
  assign any_o = |req_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/ysyx_22040125_wb_sched.sv
// Write-back scheduler + scoreboard: arbitrates NREQ requesters onto
// the RF write port and stalls decode on RAW/WAW against pending rds.
// Ports: clk/rst, req_* (requesters), iss_* (decode), rf_* (RF), wb_orphan.
import ysyx_22040125_pkg::*;

module ysyx_22040125_wb_sched #(
  parameter int XLEN = ysyx_22040125_pkg::XLEN,
  parameter int NREQ = ysyx_22040125_pkg::NREQ
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  input  logic [4:0]           iss_rs1,
  input  logic [4:0]           iss_rs2,
  output logic                 iss_stall,
  output logic                 rf_en,
  output logic [4:0]           rf_addr,
  output logic [XLEN-1:0]      rf_data,
  output logic                 wb_orphan
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            any_gnt;
  logic [PW-1:0]   rr_q, rr_d;

  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] wr_mask, peff;

  logic            rf_en_q, rf_en_d;
  logic [4:0]      rf_addr_q, rf_addr_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;
  logic            orphan_q, orphan_d;

  logic [4:0]      g_rd;
  logic [XLEN-1:0] g_data;
  logic            issue;
  logic            wr_vld;

  ysyx_22040125_rr_arb #(
    .N  (NREQ),
    .IW (PW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (any_gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    g_rd   = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        g_rd   = req_rd[5*i +: 5];
        g_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  // A register being written this cycle is forwarded by the RF,
  // so it no longer blocks readers or a new writer.
  assign wr_mask = rf_en_q ? reg_onehot(rf_addr_q) : '0;
  assign peff    = pend_q & ~wr_mask;

  assign iss_stall = iss_valid &
                     (peff[iss_rs1] | peff[iss_rs2] | peff[iss_rd]);
  assign issue     = iss_valid & ~iss_stall;

  // Set after clear: a re-issue of the register being retired wins.
  always_comb begin
    pend_d = pend_q & ~wr_mask;
    if (issue && (iss_rd != '0)) begin
      pend_d[iss_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // rd = 0 grants are consumed without a write.
  assign wr_vld    = any_gnt & (g_rd != '0);
  assign rf_en_d   = wr_vld;
  assign rf_addr_d = wr_vld ? g_rd : rf_addr_q;
  assign rf_data_d = wr_vld ? g_data : rf_data_q;
  assign orphan_d  = orphan_q | (wr_vld & ~pend_q[g_rd]);

  always_comb begin
    rr_d = rr_q;
    if (any_gnt) begin
      if (gnt_idx == PW'(NREQ - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = gnt_idx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= '0;
      rr_q      <= '0;
      rf_en_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      orphan_q  <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      rr_q      <= rr_d;
      rf_en_q   <= rf_en_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      orphan_q  <= orphan_d;
    end
  end

  assign rf_en     = rf_en_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;
  assign wb_orphan = orphan_q;

endmodule

// File: tb/tb_ysyx_22040125_wb_sched.sv
// Self-checking bench for ysyx_22040125_wb_sched.
// Directed scenarios plus random traffic against a behavioural model.
module tb_ysyx_22040125_wb_sched;

  localparam int NR = 3;
  localparam int XL = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*5-1:0] req_rd;
  logic [NR*XL-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            iss_valid;
  logic [4:0]      iss_rd, iss_rs1, iss_rs2;
  logic            iss_stall;
  logic            rf_en;
  logic [4:0]      rf_addr;
  logic [XL-1:0]   rf_data;
  logic            wb_orphan;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit [31:0] m_pend;
  int        m_rr;
  bit        m_en;
  bit [4:0]  m_addr;
  bit [63:0] m_data;
  bit        m_orph;
  int        m_lastg;

  ysyx_22040125_wb_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_stall (iss_stall),
    .rf_en     (rf_en),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .wb_orphan (wb_orphan)
  );

  always #5 clk = ~clk;

  function automatic int m_grant();
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_rr + k) % NR;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit [NR-1:0] m_ready();
    bit [NR-1:0] r;
    int g;
    r = '0;
    g = m_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic bit m_stall();
    bit [31:0] eff;
    if (!iss_valid) return 1'b0;
    eff = m_pend;
    if (m_en) eff[m_addr] = 1'b0;
    return eff[iss_rs1] | eff[iss_rs2] | eff[iss_rd];
  endfunction

  task automatic model_reset();
    m_pend = '0; m_rr = 0; m_en = 0;
    m_addr = '0; m_data = '0; m_orph = 0; m_lastg = -1;
  endtask

  task automatic idle();
    req_valid = '0; req_rd = '0; req_data = '0;
    iss_valid = 0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
  endtask

  // advance one clock, updating the model from the current inputs
  task automatic tick();
    int g;
    bit issue;
    bit [31:0] np;
    bit [4:0] rd;
    bit ne;
    g = m_grant();
    issue = iss_valid && !m_stall();
    np = m_pend;
    if (m_en) np[m_addr] = 1'b0;
    if (issue && iss_rd != 0) np[iss_rd] = 1'b1;
    ne = 0;
    if (g >= 0) begin
      rd = req_rd[5*g +: 5];
      if (rd != 0) begin
        ne = 1;
        m_addr = rd;
        m_data = req_data[XL*g +: XL];
        if (!m_pend[rd]) m_orph = 1;
      end
      m_rr = (g + 1) % NR;
    end
    m_en = ne;
    m_pend = np;
    m_lastg = g;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    model_reset();
    iss_valid = 1; iss_rs1 = 5'd9; iss_rs2 = 5'd17; iss_rd = 5'd4;
    #2;
    total++;
    if (rf_en !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 64'd0) begin
      bad++;
      $display("FAIL reset_rf got en=%b a=%0d d=%h want 0", rf_en, rf_addr, rf_data);
    end
    total++;
    if (wb_orphan !== 1'b0) begin
      bad++; $display("FAIL reset_orphan got=%b want=0", wb_orphan);
    end
    total++;
    if (iss_stall !== 1'b0 || req_ready !== 3'b000) begin
      bad++;
      $display("FAIL reset_comb got stall=%b rdy=%b want 0/000", iss_stall, req_ready);
    end
    idle();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_raw();
    apply_reset();
    iss_valid = 1; iss_rd = 5'd5;
    #1;
    total++;
    if (iss_stall !== 1'b0) begin
      bad++; $display("FAIL raw_issue_stall got=%b want=0", iss_stall);
    end
    tick();
    iss_rd = 5'd0; iss_rs1 = 5'd5;
    req_valid = 3'b001; req_rd[4:0] = 5'd5; req_data[63:0] = 64'hDEAD;
    #1;
    total++;
    if (iss_stall !== 1'b1) begin
      bad++; $display("FAIL raw_dep_stall got=%b want=1", iss_stall);
    end
    total++;
    if (req_ready !== 3'b001) begin
      bad++; $display("FAIL raw_grant got=%b want=001", req_ready);
    end
    tick();
    req_valid = '0;
    total++;
    if (rf_en !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 64'hDEAD) begin
      bad++;
      $display("FAIL raw_write got en=%b a=%0d d=%h want 1/5/dead", rf_en, rf_addr, rf_data);
    end
    #1;
    total++;
    if (iss_stall !== 1'b0) begin
      bad++; $display("FAIL raw_forward_stall got=%b want=0", iss_stall);
    end
    tick();
    total++;
    if (wb_orphan !== 1'b0 || rf_en !== 1'b0) begin
      bad++;
      $display("FAIL raw_after got orph=%b en=%b want 0/0", wb_orphan, rf_en);
    end
    idle();
  endtask

  task automatic test_round_robin();
    int exp_g[4] = '{0, 1, 2, 0};
    apply_reset();
    req_valid = 3'b111;
    req_rd = {5'd3, 5'd2, 5'd1};
    req_data = {64'hC, 64'hB, 64'hA};
    for (int c = 0; c < 4; c++) begin
      bit [2:0] eg;
      eg = 3'b000;
      eg[exp_g[c]] = 1'b1;
      #1;
      total++;
      if (req_ready !== eg) begin
        bad++; $display("FAIL rr_grant%0d got=%b want=%b", c, req_ready, eg);
      end
      tick();
      total++;
      if (rf_en !== 1'b1 || rf_addr !== 5'(exp_g[c] + 1)) begin
        bad++;
        $display("FAIL rr_write%0d got en=%b a=%0d want 1/%0d", c, rf_en, rf_addr, exp_g[c] + 1);
      end
    end
    idle();
  endtask

  task automatic test_rd_zero();
    apply_reset();
    req_valid = 3'b010;
    req_rd = '0;
    req_data = {64'h0, 64'h1234, 64'h0};
    #1;
    total++;
    if (req_ready !== 3'b010) begin
      bad++; $display("FAIL rd0_grant got=%b want=010", req_ready);
    end
    tick();
    req_valid = '0;
    total++;
    if (rf_en !== 1'b0 || wb_orphan !== 1'b0) begin
      bad++; $display("FAIL rd0_silent got en=%b orph=%b want 0/0", rf_en, wb_orphan);
    end
    idle();
  endtask

  task automatic test_orphan();
    apply_reset();
    req_valid = 3'b001; req_rd[4:0] = 5'd7; req_data[63:0] = 64'h77;
    #1;
    tick();
    req_valid = '0;
    total++;
    if (wb_orphan !== 1'b1 || rf_en !== 1'b1 || rf_addr !== 5'd7) begin
      bad++;
      $display("FAIL orphan_set got orph=%b en=%b a=%0d want 1/1/7", wb_orphan, rf_en, rf_addr);
    end
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (wb_orphan !== 1'b1) begin
      bad++; $display("FAIL orphan_sticky got=%b want=1", wb_orphan);
    end
    rst = 1;
    model_reset();
    #2;
    total++;
    if (wb_orphan !== 1'b0) begin
      bad++; $display("FAIL orphan_clear got=%b want=0", wb_orphan);
    end
    @(posedge clk);
    #1;
    rst = 0;
    idle();
  endtask

  task automatic test_set_wins_and_reset();
    apply_reset();
    iss_valid = 1; iss_rd = 5'd3;
    #1;
    tick();
    iss_valid = 0; iss_rd = 0;
    req_valid = 3'b001; req_rd[4:0] = 5'd3; req_data[63:0] = 64'h33;
    #1;
    tick();
    req_valid = '0;
    iss_valid = 1; iss_rd = 5'd3;
    #1;
    total++;
    if (rf_en !== 1'b1 || rf_addr !== 5'd3 || iss_stall !== 1'b0) begin
      bad++;
      $display("FAIL sw_same_cycle got en=%b a=%0d stall=%b want 1/3/0", rf_en, rf_addr, iss_stall);
    end
    tick();
    iss_rd = 0; iss_rs1 = 5'd3;
    #1;
    total++;
    if (iss_stall !== 1'b1) begin
      bad++; $display("FAIL sw_pend_set got stall=%b want=1", iss_stall);
    end
    req_valid = 3'b111;
    req_rd = {5'd5, 5'd4, 5'd3};
    req_data = {64'h55, 64'h44, 64'h33};
    tick();
    total++;
    if (rf_en !== 1'b1 || rf_addr !== 5'd4) begin
      bad++; $display("FAIL sw_pre_rst got en=%b a=%0d want 1/4", rf_en, rf_addr);
    end
    rst = 1;
    model_reset();
    #1;
    total++;
    if (rf_en !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 64'd0 || wb_orphan !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_regs got en=%b a=%0d d=%h o=%b want 0", rf_en, rf_addr, rf_data, wb_orphan);
    end
    total++;
    if (iss_stall !== 1'b0 || req_ready !== 3'b001) begin
      bad++;
      $display("FAIL mid_rst_comb got stall=%b rdy=%b want 0/001", iss_stall, req_ready);
    end
    idle();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!(req_valid[i] && i != m_lastg)) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          req_rd[5*i +: 5] = 5'($urandom_range(0, 7));
          req_data[XL*i +: XL] = {$urandom, $urandom};
        end
      end
      iss_valid = $urandom_range(0, 1) == 1;
      iss_rd = 5'($urandom_range(0, 7));
      iss_rs1 = 5'($urandom_range(0, 7));
      iss_rs2 = 5'($urandom_range(0, 7));
      #1;
      total++;
      if (iss_stall !== m_stall() || req_ready !== m_ready()) begin
        bad++;
        $display("FAIL rnd_comb c=%0d got stall=%b rdy=%b want %b/%b",
                 c, iss_stall, req_ready, m_stall(), m_ready());
      end
      tick();
      total++;
      if (rf_en !== m_en || wb_orphan !== m_orph ||
          (m_en && (rf_addr !== m_addr || rf_data !== m_data))) begin
        bad++;
        $display("FAIL rnd_regs c=%0d got en=%b a=%0d d=%h o=%b want %b/%0d/%h/%b",
                 c, rf_en, rf_addr, rf_data, wb_orphan, m_en, m_addr, m_data, m_orph);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    test_reset();
    test_raw();
    test_round_robin();
    test_rd_zero();
    test_orphan();
    test_set_wins_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
